// File: rtl/branch_predict_unit_if.sv
// branch_predict_unit_if
//   Fetch/EX signal bundle between the fetch pipeline and branch_predict_unit.
//   master : the pipeline side; drives fetch PC, BTB result and EX resolution,
//            and receives next-PC and redirect.
//   slave  : the predictor.
//   Fetch side : pc, pc_add4, PCEN, branch_found, branch_addr
//   EX side    : ex_is_branch, ex_taken, ex_target, ex_pc_add4
//   Outputs    : npc, pred_taken, mispredict, correct_npc
//   Optional   : stat_branches, stat_mispredicts (only when PRED_STATS_EN is defined)
interface branch_predict_unit_if;
    logic [31:0] pc;
    logic [31:0] pc_add4;
    logic        PCEN;
    logic        branch_found;
    logic [31:0] branch_addr;
    logic        ex_is_branch;
    logic        ex_taken;
    logic [31:0] ex_target;
    logic [31:0] ex_pc_add4;
    logic [31:0] npc;
    logic        pred_taken;
    logic        mispredict;
    logic [31:0] correct_npc;
`ifdef PRED_STATS_EN
    logic [31:0] stat_branches;
    logic [31:0] stat_mispredicts;
`endif

    modport master (
        output pc, pc_add4, PCEN, branch_found, branch_addr,
               ex_is_branch, ex_taken, ex_target, ex_pc_add4,
        input  npc, pred_taken, mispredict, correct_npc
`ifdef PRED_STATS_EN
        , input stat_branches, stat_mispredicts
`endif
    );

    modport slave (
        input  pc, pc_add4, PCEN, branch_found, branch_addr,
               ex_is_branch, ex_taken, ex_target, ex_pc_add4,
        output npc, pred_taken, mispredict, correct_npc
`ifdef PRED_STATS_EN
        , output stat_branches, stat_mispredicts
`endif
    );
endinterface

// File: rtl/branch_predict_unit.sv
// branch_predict_unit
//   Fetch-stage next-PC selector behind the BTB. A direct-mapped table of
//   2-bit saturating counters gates the BTB hit; each prediction rides the
//   ID/EX tracking pipe and is checked against the resolved outcome in EX,
//   where a mismatch raises mispredict and redirects npc to correct_npc.
//   Ports : CLK, RST (async, active high), bp (branch_predict_unit_if.slave)
//   Params: IDX_W    - counter index width, table has 2**IDX_W entries
//           CTR_INIT - counter reset value
//   Macro : PRED_STATS_EN - adds stat_branches / stat_mispredicts counters
module branch_predict_unit #(
    parameter int         IDX_W    = 4,
    parameter logic [1:0] CTR_INIT = 2'b01
) (
    input logic                  CLK,
    input logic                  RST,
    branch_predict_unit_if.slave bp
);
    localparam int ENTRIES = 1 << IDX_W;

    typedef struct packed {
        logic             pt;
        logic [31:0]      tgt;
        logic [IDX_W-1:0] idx;
    } pred_t;

    logic [1:0]       ctr [ENTRIES];
    logic [IDX_W-1:0] idx;
    logic             pred_taken;
    logic [31:0]      pred_npc;
    logic             mispredict;
    logic [31:0]      correct_npc;

    // vld_pipe[1] = ID valid, vld_pipe[2] = EX valid
    logic [2:1] vld_pipe;
    pred_t      id_p, ex_p;
    logic       id_v, ex_v;

    logic       ctr_upd;
    logic [1:0] ctr_cur, ctr_nxt;

    assign id_v = vld_pipe[1];
    assign ex_v = vld_pipe[2];

    // Prediction: table read is the pre-update value even if EX writes the same entry.
    assign idx        = bp.pc[IDX_W+1:2];
    assign pred_taken = bp.branch_found & ctr[idx][1];
    assign pred_npc   = pred_taken ? bp.branch_addr : bp.pc_add4;

    // Resolution: a taken/taken pair still mispredicts when the BTB target was wrong.
    assign mispredict  = ex_v & bp.ex_is_branch &
                         ((ex_p.pt != bp.ex_taken) |
                          (ex_p.pt & bp.ex_taken & (ex_p.tgt != bp.ex_target)));
    assign correct_npc = bp.ex_taken ? bp.ex_target : bp.ex_pc_add4;

    assign bp.pred_taken  = pred_taken;
    assign bp.mispredict  = mispredict;
    assign bp.correct_npc = correct_npc;
    assign bp.npc         = mispredict ? correct_npc : pred_npc;

    // Tracking pipe: advances only with PCEN so a held redirect stays asserted.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            vld_pipe <= '0;
            id_p     <= '0;
            ex_p     <= '0;
        end else if (bp.PCEN) begin
            if (mispredict) begin
                vld_pipe <= '0;
            end else begin
                vld_pipe <= {vld_pipe[1], 1'b1};
                id_p     <= '{pt: pred_taken, tgt: bp.branch_addr, idx: idx};
                ex_p     <= id_p;
            end
        end
    end

    // Direction training uses the resolved direction even on a target-only mispredict.
    assign ctr_upd = bp.PCEN & ex_v & bp.ex_is_branch;
    assign ctr_cur = ctr[ex_p.idx];

    always_comb begin
        ctr_nxt = ctr_cur;
        if (bp.ex_taken) begin
            if (ctr_cur != 2'b11) ctr_nxt = ctr_cur + 2'b01;
        end else begin
            if (ctr_cur != 2'b00) ctr_nxt = ctr_cur - 2'b01;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < ENTRIES; i++) ctr[i] <= CTR_INIT;
        end else if (ctr_upd) begin
            ctr[ex_p.idx] <= ctr_nxt;
        end
    end

`ifdef PRED_STATS_EN
    logic [31:0] stat_branches, stat_mispredicts;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            stat_branches    <= '0;
            stat_mispredicts <= '0;
        end else if (ctr_upd) begin
            stat_branches <= stat_branches + 32'd1;
            if (mispredict) stat_mispredicts <= stat_mispredicts + 32'd1;
        end
    end

    assign bp.stat_branches    = stat_branches;
    assign bp.stat_mispredicts = stat_mispredicts;
`endif

    // PC bits outside the index field do not affect the prediction.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{bp.pc[31:IDX_W+2], bp.pc[1:0], id_v};
endmodule

// File: tb/tb_branch_predict_unit.sv
// tb_branch_predict_unit
//   Directed bench for branch_predict_unit: expected outputs are pushed to a
//   scoreboard queue as each step is driven and popped when the combinational
//   outputs are sampled. Also covers stats when PRED_STATS_EN is defined.
module tb_branch_predict_unit;
    logic CLK = 1'b0;
    logic RST = 1'b0;
    always #5 CLK = ~CLK;

    branch_predict_unit_if bp();

    branch_predict_unit #(.IDX_W(4), .CTR_INIT(2'b01)) dut (
        .CLK (CLK),
        .RST (RST),
        .bp  (bp.slave)
    );

    typedef struct {
        string       tag;
        logic [31:0] npc;
        logic        pt;
        logic        mp;
        logic [31:0] cnpc;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic cmp32(input string tag, input string fld,
                         input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s.%s got=%h exp=%h", tag, fld, got, exp);
        end
    endtask

    task automatic pop_check();
        exp_t e;
        e = sb.pop_front();
        cmp32(e.tag, "npc",         bp.npc,                 e.npc);
        cmp32(e.tag, "pred_taken",  {31'd0, bp.pred_taken}, {31'd0, e.pt});
        cmp32(e.tag, "mispredict",  {31'd0, bp.mispredict}, {31'd0, e.mp});
        cmp32(e.tag, "correct_npc", bp.correct_npc,          e.cnpc);
    endtask

    // Stimulus has already been driven; queue the expectation, let it settle, compare.
    task automatic expect_out(input string tag, input logic [31:0] npc, input logic pt,
                              input logic mp, input logic [31:0] cnpc);
        sb.push_back('{tag: tag, npc: npc, pt: pt, mp: mp, cnpc: cnpc});
        #1;
        pop_check();
    endtask

`ifdef PRED_STATS_EN
    task automatic expect_stats(input string tag, input logic [31:0] b, input logic [31:0] m);
        cmp32(tag, "stat_branches",    bp.stat_branches,    b);
        cmp32(tag, "stat_mispredicts", bp.stat_mispredicts, m);
    endtask
`endif

    task automatic next_cyc();
        @(posedge CLK);
        #2;
    endtask

    initial begin
        bp.pc           = 32'h100;
        bp.pc_add4      = 32'h104;
        bp.PCEN         = 1'b0;
        bp.branch_found = 1'b1;
        bp.branch_addr  = 32'h200;
        bp.ex_is_branch = 1'b0;
        bp.ex_taken     = 1'b0;
        bp.ex_target    = 32'h200;
        bp.ex_pc_add4   = 32'h104;
        #1 RST = 1'b1;
        #2;
        expect_out("reset", 32'h104, 1'b0, 1'b0, 32'h104);
`ifdef PRED_STATS_EN
        expect_stats("reset", 32'd0, 32'd0);
`endif
        @(posedge CLK);
        #2;
        RST     = 1'b0;
        bp.PCEN = 1'b1;

        // Fill ID then EX with the 0x100 prediction (not taken, ctr=01).
        next_cyc();
        next_cyc();
        bp.ex_is_branch = 1'b1;
        bp.ex_taken     = 1'b1;
        expect_out("train1_mp", 32'h200, 1'b0, 1'b1, 32'h200);
        next_cyc();                               // ctr 01->10, flush
        expect_out("train1_flush", 32'h200, 1'b1, 1'b0, 32'h200);
        next_cyc();
        next_cyc();                               // EX holds a taken prediction
        expect_out("train2_ok", 32'h200, 1'b1, 1'b0, 32'h200);
        next_cyc();                               // ctr 10->11
        bp.ex_taken = 1'b0;
        expect_out("nt_mp", 32'h104, 1'b1, 1'b1, 32'h104);
        next_cyc();                               // ctr 11->10, flush
        expect_out("nt_flush", 32'h200, 1'b1, 1'b0, 32'h104);
        bp.ex_taken = 1'b1;
        next_cyc();
        next_cyc();
        expect_out("retrain", 32'h200, 1'b1, 1'b0, 32'h200);
        next_cyc();                               // ctr 10->11
        bp.ex_target = 32'h300;
        expect_out("tgt_mp", 32'h300, 1'b1, 1'b1, 32'h300);

        // Redirect must hold while the pipe is stalled.
        bp.PCEN = 1'b0;
        for (int i = 0; i < 3; i++) begin
            next_cyc();
            expect_out($sformatf("hold%0d", i), 32'h300, 1'b1, 1'b1, 32'h300);
        end
`ifdef PRED_STATS_EN
        expect_stats("hold", 32'd4, 32'd2);
`endif
        bp.PCEN = 1'b1;
        next_cyc();                               // ctr stays 11, flush
        expect_out("sat_flush", 32'h200, 1'b1, 1'b0, 32'h300);
`ifdef PRED_STATS_EN
        expect_stats("sat_flush", 32'd5, 32'd3);
`endif

        // Non-branch in EX.
        bp.ex_is_branch = 1'b0;
        bp.ex_taken     = 1'b0;
        bp.ex_target    = 32'h200;
        next_cyc();
        next_cyc();
        expect_out("nonbranch", 32'h200, 1'b1, 1'b0, 32'h104);
        next_cyc();
`ifdef PRED_STATS_EN
        expect_stats("nonbranch", 32'd5, 32'd3);
`endif

        // Other index, BTB miss, then a mispredict interrupted by async reset.
        bp.pc          = 32'h104;
        bp.pc_add4     = 32'h108;
        bp.branch_addr = 32'h400;
        expect_out("idx1", 32'h108, 1'b0, 1'b0, 32'h104);
        bp.pc           = 32'h100;
        bp.pc_add4      = 32'h104;
        bp.branch_addr  = 32'h200;
        bp.branch_found = 1'b0;
        expect_out("no_btb", 32'h104, 1'b0, 1'b0, 32'h104);
        bp.branch_found = 1'b1;
        bp.ex_is_branch = 1'b1;
        expect_out("pre_rst_mp", 32'h104, 1'b1, 1'b1, 32'h104);
        RST = 1'b1;
        expect_out("rst_async", 32'h104, 1'b0, 1'b0, 32'h104);
`ifdef PRED_STATS_EN
        expect_stats("rst_async", 32'd0, 32'd0);
`endif
        next_cyc();
        RST         = 1'b0;
        bp.ex_taken = 1'b1;
        next_cyc();
        next_cyc();
        expect_out("post_rst_mp", 32'h200, 1'b0, 1'b1, 32'h200);
        next_cyc();                               // 01->10 proves counters restarted at 01
        expect_out("post_rst_ctr", 32'h200, 1'b1, 1'b0, 32'h200);
`ifdef PRED_STATS_EN
        expect_stats("post_rst", 32'd1, 32'd1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/branch_predict_unit.md
Name: branch_predict_unit

Overview:
- Fetch-stage next-PC selector sitting directly downstream of the BTB.
- Consumes the BTB hit and target for the current fetch PC and gates them with a direct-mapped table of 2-bit saturating direction counters to produce the next PC.
- Carries each prediction through ID and EX.
- At EX, compares it with the resolved branch outcome and raises a mispredict redirect plus flush.

Parameters:
- IDX_W, 4, counter table index width; table has 2**IDX_W entries, indexed by pc[IDX_W+1:2].
- CTR_INIT, 2'b01, counter reset value (weakly not-taken).

Ports:
- CLK  input  1  system clock; all state on rising edge.
- RST  input  1  asynchronous, active-high reset.
- pc  input  32  current fetch PC.
- pc_add4  input  32  pc + 4.
- PCEN  input  1  pipeline advance enable; the PC and the IF/ID and ID/EX latches move together.
- branch_found  input  1  BTB hit for pc.
- branch_addr  input  32  BTB predicted target for pc.
- ex_is_branch  input  1  instruction in EX is a conditional branch.
- ex_taken  input  1  resolved branch direction in EX.
- ex_target  input  32  resolved branch target in EX.
- ex_pc_add4  input  32  PC+4 of the EX instruction.
- npc  output  32  next fetch PC.
- pred_taken  output  1  current fetch predicted taken.
- mispredict  output  1  EX branch mispredicted; flush IF/ID and ID/EX.
- correct_npc  output  32  recovery PC when mispredict=1.

Behaviour:
- Reset (async, RST=1):
  - all counters <= CTR_INIT.
  - id_v, ex_v <= 0; id_pt, ex_pt <= 0; id_tgt, ex_tgt <= 0; id_idx, ex_idx <= 0.
  - Outputs are combinational. With mispredict=0 forced by ex_v=0, they settle to pred_taken = branch_found & CTR_INIT[1], and npc = pc_add4 when not taken.
  - Reset asserted mid-operation discards all in-flight predictions; there is no partial update.
- Prediction (combinational, zero latency):
  - idx = pc[IDX_W+1:2].
  - pred_taken = branch_found & ctr[idx][1].
  - pred_npc = pred_taken ? branch_addr : pc_add4.
- Resolution (combinational):
  - mispredict = ex_v & ex_is_branch & ((ex_pt != ex_taken) | (ex_pt & ex_taken & ex_tgt != ex_target)).
  - correct_npc = ex_taken ? ex_target : ex_pc_add4.
  - npc = mispredict ? correct_npc : pred_npc. Mispredict has priority over any fetch prediction.
- Tracking pipe (updates only when PCEN=1):
  - If mispredict: id_v <= 0, ex_v <= 0 (flush).
  - Otherwise: id_v <= 1, id_pt <= pred_taken, id_tgt <= branch_addr, id_idx <= idx; ex_* <= id_*.
  - PCEN=0 holds all pipe registers, including during a mispredict (redirect stays asserted until PCEN).
- Counter update (when PCEN=1 & ex_v & ex_is_branch):
  - ctr[ex_idx] <= ex_taken ? sat_inc : sat_dec.
  - Saturates at 2'b11 and 2'b00; no wrap.
- Non-branch in EX: no counter change, mispredict=0.
- Same-index read and write in one cycle: the fetch read returns the pre-update value (no bypass).
- Counter updates from a mispredicting branch still occur, in the same cycle as the flush.
- A taken prediction with a wrong target is a mispredict, but its counter update still counts as taken.

Optional Feature:
- PRED_STATS_EN:
  - Adds outputs stat_branches[31:0] and stat_mispredicts[31:0].
  - Both reset to 0 and increment on each counted update (PCEN & ex_v & ex_is_branch), and on each such cycle with mispredict=1, respectively.
  - Both wrap at 2^32.
- Without the macro: these ports and registers do not exist; behaviour is otherwise identical.

Test Plan:
- Reset, then pc=0x100, pc_add4=0x104, branch_found=1, branch_addr=0x200 -> pred_taken=0, npc=0x104 (CTR_INIT=01).
- Resolve the same branch taken twice with PCEN=1, ex_target=0x200 -> counter goes 01->10->11; a later fetch of 0x100 with a BTB hit gives pred_taken=1, npc=0x200.
- Predicted taken (ctr=11) and resolved not-taken with ex_pc_add4=0x104 -> mispredict=1, npc=correct_npc=0x104; next edge id_v=ex_v=0; counter goes 11->10.
- Predicted taken to 0x200 and resolved taken to 0x300 -> mispredict=1, npc=0x300; counter stays 11 (saturation).
- Mispredict held with PCEN=0 for 3 cycles -> mispredict stays 1; no counter change and no flush until the PCEN=1 edge.
- Assert RST mid-stream with ex_v=1 -> mispredict drops to 0 immediately and all counters read 01; with PRED_STATS_EN, both stats read 0.
